// File: rtl/reg_share_pkg.sv
// Shared types and constants for the holding-register share arbiter.
package reg_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP
    } arb_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int N_MAX      = 8;

    // Width of the gap counter; holds GAP_CYCLES-1 for GAP_CYCLES up to 15.
    localparam int GAP_W = 4;

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Circular priority encoder: first set bit of req at or above ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int j;

    // Walk offsets from the far end down so the nearest offset to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one holding register among N requesters;
// issues a single-cycle load plus ack to the winner, then a fixed idle gap.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N*DATA_W-1:0]    req_data,
    output logic                   reg_load,
    output logic [DATA_W-1:0]      reg_data,
    output logic [N-1:0]           ack,
    output logic [$clog2(N)-1:0]   owner,
    output logic                   busy
);

    localparam int IW = $clog2(N);
    localparam logic [GAP_W-1:0] GAP_INIT =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    arb_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [GAP_W-1:0]  gap_cnt;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     ptr_next;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign ptr_next = (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            reg_load <= 1'b0;
            reg_data <= '0;
            ack      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    reg_load <= 1'b0;
                    ack      <= '0;
                    if (pick_found) begin
                        reg_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                        ack      <= N'(1) << pick_idx;
                        reg_load <= 1'b1;
                        owner    <= pick_idx;
                        rr_ptr   <= ptr_next;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    reg_load <= 1'b0;
                    ack      <= '0;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_INIT;
                        state   <= ST_GAP;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    // Counter sits at 0 during the last gap cycle.
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    reg_load <= 1'b0;
                    ack      <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: one instance with a 1-cycle gap,
// one with no gap, sharing clock and reset.
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;

    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            reg_load;
    logic [DW-1:0]   reg_data;
    logic [N-1:0]    ack;
    logic [1:0]      owner;
    logic            busy;

    logic [N-1:0]    req_z;
    logic [N*DW-1:0] req_data_z;
    logic            reg_load_z;
    logic [DW-1:0]   reg_data_z;
    logic [N-1:0]    ack_z;
    logic [1:0]      owner_z;
    logic            busy_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_share_arbiter #(.N(N), .DATA_W(DW), .GAP_CYCLES(1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .reg_load (reg_load),
        .reg_data (reg_data),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy)
    );

    reg_share_arbiter #(.N(N), .DATA_W(DW), .GAP_CYCLES(0)) u_dut_z (
        .clk      (clk),
        .reset    (reset),
        .req      (req_z),
        .req_data (req_data_z),
        .reg_load (reg_load_z),
        .reg_data (reg_data_z),
        .ack      (ack_z),
        .owner    (owner_z),
        .busy     (busy_z)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_data   = '0;
        req_z      = '0;
        req_data_z = '0;

        // Reset state
        tick();
        tick();
        chk("rst_load",  32'(reg_load), 32'd0);
        chk("rst_ack",   32'(ack),      32'd0);
        chk("rst_owner", 32'(owner),    32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_data",  32'(reg_data), 32'd0);
        chk("rst_z",     32'({reg_load_z, ack_z, busy_z}), 32'd0);

        // Single request from requester 2
        reset = 1'b0;
        req   = 4'b0100;
        req_data[23:16] = 8'hA5;
        tick();
        chk("s_load",  32'(reg_load), 32'd1);
        chk("s_ack",   32'(ack),      32'h4);
        chk("s_data",  32'(reg_data), 32'hA5);
        chk("s_owner", 32'(owner),    32'd2);
        chk("s_busy",  32'(busy),     32'd1);
        req = '0;
        tick();
        chk("s_gap_load", 32'(reg_load), 32'd0);
        chk("s_gap_ack",  32'(ack),      32'd0);
        chk("s_gap_busy", 32'(busy),     32'd1);
        tick();
        chk("s_idle_busy", 32'(busy), 32'd0);
        chk("s_hold_data", 32'(reg_data), 32'hA5);

        // Wrap-around: pointer is at 3, requesters 0 and 1 ask
        req      = 4'b0011;
        req_data = {8'h00, 8'h00, 8'h21, 8'h20};
        tick();
        chk("w0_ack",   32'(ack),      32'h1);
        chk("w0_owner", 32'(owner),    32'd0);
        chk("w0_data",  32'(reg_data), 32'h20);
        req = 4'b0010;
        tick();
        tick();
        chk("w_idle_load", 32'(reg_load), 32'd0);
        tick();
        chk("w1_ack",   32'(ack),      32'h2);
        chk("w1_owner", 32'(owner),    32'd1);
        chk("w1_data",  32'(reg_data), 32'h21);
        req = '0;
        tick();
        tick();

        // Round-robin rotation from a fresh pointer
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_load",  32'(reg_load), 32'd1);
            chk("rr_ack",   32'(ack),      32'(1 << (k % 4)));
            chk("rr_owner", 32'(owner),    32'(k % 4));
            chk("rr_data",  32'(reg_data), 32'(8'h10 + (k % 4)));
            if (k < 4) begin
                tick();
                chk("rr_gap_load", 32'(reg_load), 32'd0);
                tick();
                chk("rr_idle_load", 32'(reg_load), 32'd0);
            end
        end
        req = '0;
        tick();
        tick();
        chk("rr_end_busy", 32'(busy), 32'd0);

        // Reset during LOAD of a grant to requester 1
        req = 4'b0010;
        req_data[15:8] = 8'h3C;
        tick();
        chk("m_ack",  32'(ack),      32'h2);
        chk("m_load", 32'(reg_load), 32'd1);
        reset = 1'b1;
        tick();
        chk("m_rst_load", 32'(reg_load), 32'd0);
        chk("m_rst_ack",  32'(ack),      32'd0);
        chk("m_rst_busy", 32'(busy),     32'd0);
        reset = 1'b0;
        tick();
        chk("m_regrant_load", 32'(reg_load), 32'd1);
        chk("m_regrant_ack",  32'(ack),      32'h2);
        chk("m_regrant_data", 32'(reg_data), 32'h3C);
        req = '0;
        tick();
        tick();

        // No gap: continuous request from requester 0
        req_z = 4'b0001;
        req_data_z[7:0] = 8'h77;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("z_load", 32'(reg_load_z), 32'((k % 2) == 0));
            chk("z_busy", 32'(busy_z),     32'((k % 2) == 0));
            chk("z_ack",  32'(ack_z),      ((k % 2) == 0) ? 32'h1 : 32'h0);
        end
        chk("z_data", 32'(reg_data_z), 32'h77);
        req_z = '0;

        // Idle: nothing requested, outputs stay quiet and data holds
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_pulses", 32'({reg_load, ack, busy}), 32'd0);
            chk("idle_data",   32'(reg_data), 32'h3C);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit holding register among N requesters.
- Selects one requester per transaction and captures its data.
- Drives the register's load-enable and data-in for exactly one cycle, then acks the winner.
- Sits between the requester blocks and the holding register. The register's own clock and reset are driven from the same clk/reset nets.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- DATA_W, 8, data width; must match the holding register width.
- GAP_CYCLES, 1, idle cycles forced after each load before the next arbitration; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request per requester; level, held until the matching ack.
- req_data  input  N*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]. Must be stable while req[i]=1.
- reg_load  output  1  load-enable to holding register; single-cycle pulse.
- reg_data  output  DATA_W  data to holding register; valid when reg_load=1.
- ack  output  N  one-hot pulse to the winner, coincident with reg_load.
- owner  output  max(1,$clog2(N))  index of the last winner.
- busy  output  1  high in LOAD and GAP states.

Behaviour:
- Reset: synchronous, active-high; clk and reset are the only clock/reset.
  - Values on the first rising edge with reset=1: state=IDLE, reg_load=0, reg_data=0, ack=0, owner=0, busy=0, rr_ptr=0, gap counter=0.
  - Reset overrides every other input.
  - Reset asserted during LOAD or GAP: the pulse in flight is not completed and no ack is issued. The requester keeps req high and is re-arbitrated after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, LOAD, GAP.
  - IDLE:
    - If req != 0, choose the winner w as the first set bit of req searched circularly from rr_ptr upward (wrapping N-1 -> 0).
    - On that edge, capture req_data slice w into reg_data, set ack[w]=1, reg_load=1, owner=w, rr_ptr=(w+1) mod N, and move to LOAD.
    - If req == 0, stay in IDLE with all pulses 0.
  - LOAD (exactly 1 cycle): reg_load=1, ack=onehot(w), busy=1.
    - Next state is GAP with counter=GAP_CYCLES-1 if GAP_CYCLES>0; otherwise IDLE.
    - reg_load and ack clear on leaving LOAD.
  - GAP: busy=1, no arbitration.
    - Counter decrements each cycle.
    - Move to IDLE in the cycle after the counter reaches 0 (GAP lasts exactly GAP_CYCLES cycles).
- Latency: with req first seen high in IDLE at cycle t, reg_load and ack are high during cycle t+1. The holding register updates at the end of cycle t+1.
- Back-to-back throughput: one load per 2+GAP_CYCLES cycles.
- Requester protocol:
  - Deassert req in the cycle after ack.
  - If req[w] is still high when IDLE is re-entered, it is treated as a new request and arbitrated fairly (it has lowest priority after just winning).
- Simultaneous requests: resolved strictly by the rotating pointer; no fixed priority.
- Fairness: with all N requesting continuously, each is served once per N transactions.
- Requests arriving in LOAD or GAP are held off with no loss, since req is a level.
- reg_data holds its value outside LOAD; it changes only on a grant.
- A req deasserted before grant is simply not selected, with no error.

Decomposition:
- Shared package reg_share_pkg:
  - typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_GAP} arb_state_t.
  - DATA_W_DEF=8 and N_MAX=8 constants.
- One sub-module, rr_pick.
  - Combinational circular priority encoder with inputs req[N] and ptr, outputs found and idx.
  - Instantiated once; the FSM, capture registers and gap counter live in reg_share_arbiter.

Test Plan:
1. Reset then single request: reset 2 cycles, then req=4'b0100, req_data[23:16]=8'hA5 -> next cycle reg_load=1, ack=4'b0100, reg_data=8'hA5, owner=2. Following cycle reg_load=0, busy=1 for 1 GAP cycle.
2. Round-robin rotation: req=4'b1111 held, data i = 8'h10+i, GAP_CYCLES=1 -> grants in order 0,1,2,3,0 with reg_data 10,11,12,13,10, one load every 3 cycles.
3. Wrap-around: rr_ptr=3 after serving requester 2, then req=4'b0011 -> requester 0 wins, then requester 1 wins.
4. Reset mid-transaction: assert reset in the LOAD cycle of a grant to requester 1 -> next cycle reg_load=0, ack=0, state IDLE. The same request is re-granted 1 cycle after reset deasserts.
5. GAP_CYCLES=0: continuous req=4'b0001 -> reg_load toggles 1,0,1,0 (one load every 2 cycles); busy high only in LOAD cycles.
6. No request: req=0 for 20 cycles -> reg_load, ack and busy stay 0; reg_data holds its last value.
